reg_bank_arbiter: RTL and testbench

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

---
 rtl/reg_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 35 +++
 rtl/reg_bank_arbiter.sv | 146 ++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the register-bank arbiter.
// State enum, default sizing constants and a small index helper.
package reg_arb_pkg;

   localparam int unsigned NREQ_DEFAULT = 4;
   localparam int unsigned W_DEFAULT    = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Wrapping increment of a requester index in the range 0..n-1.
   function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request bit scanning upward from ptr, wrapping at NREQ-1.
module rr_pick #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic                    valid,
   output logic [$clog2(NREQ)-1:0] idx
);

   localparam int unsigned IW = $clog2(NREQ);

   // Scan NREQ candidates starting at ptr; the first hit wins.
   always_comb begin
      int unsigned     c;
      logic [IW-1:0]   cand;
      valid = 1'b0;
      idx   = '0;
      c     = 0;
      cand  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         c = 32'(ptr) + k;
         if (c >= NREQ) begin
            c = c - NREQ;
         end
         cand = IW'(c);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter guarding one shared storage register.
// The granted requester may write the register; everyone else is ignored.
// Optional feature: define ARB_TIMEOUT_EN to force release of an owner that has
// held the grant for MAX_HOLD cycles while another requester waits.
module reg_bank_arbiter
   import reg_arb_pkg::*;
#(
   parameter int unsigned NREQ     = NREQ_DEFAULT,
   parameter int unsigned W        = W_DEFAULT,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         we,
   input  logic [NREQ*W-1:0]       wdata,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    busy,
   output logic [W-1:0]            q,
   output logic                    timeout_evt
);

   localparam int unsigned IW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || MAX_HOLD < 1) begin : g_param_check
      $error("reg_bank_arbiter: parameter out of range");
   end

   arb_state_e      state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [W-1:0]    q_q, q_d;

   logic [W-1:0]    wdata_arr [NREQ];
   logic [NREQ-1:0] owner_oh;
   logic [NREQ-1:0] pick_mask;
   logic            force_rel;
   logic            pick_valid;
   logic [IW-1:0]   pick_idx;
   logic            new_grant;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign wdata_arr[i] = wdata[i*W +: W];
   end

   assign owner_oh = NREQ'(1) << owner_q;

   // A forced release must not hand the grant straight back to the owner.
   assign pick_mask = force_rel ? (req & ~owner_oh) : req;

   rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req   (pick_mask),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // Next-state: arbitrate when idle, on owner release or on forced release;
   // otherwise hold the grant. The owner's write lands even in its release cycle.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      q_d       = q_q;
      new_grant = 1'b0;

      if (state_q == BUSY && gnt_q[owner_q] && we[owner_q]) begin
         q_d = wdata_arr[owner_q];
      end

      if (state_q == IDLE || !req[owner_q] || force_rel) begin
         if (pick_valid) begin
            state_d   = BUSY;
            gnt_d     = NREQ'(1) << pick_idx;
            owner_d   = pick_idx;
            ptr_d     = IW'(next_idx(32'(pick_idx), NREQ));
            new_grant = 1'b1;
         end else begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      end
   end

   // State register with synchronous reset; reset also discards a pending write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         q_q     <= q_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned   CW        = $clog2(MAX_HOLD + 1);
   // hold_q counts completed cycles of the current grant, so it equals HOLD_LAST
   // during the owner's MAX_HOLD-th granted cycle and saturates there.
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   logic [CW-1:0] hold_q;
   logic          tevt_q;

   // Release at this edge when the hold budget is spent and someone else waits.
   assign force_rel = (state_q == BUSY) && req[owner_q] && (hold_q == HOLD_LAST) &&
                      (|(req & ~owner_oh));

   // Hold counter and one-cycle timeout pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
         tevt_q <= 1'b0;
      end else begin
         tevt_q <= force_rel;
         if (new_grant) begin
            hold_q <= '0;
         end else if (state_q == BUSY && hold_q != HOLD_LAST) begin
            hold_q <= hold_q + 1'b1;
         end
      end
   end

   assign timeout_evt = tevt_q;
`else
   assign force_rel   = 1'b0;
   assign timeout_evt = 1'b0;
`endif

   assign gnt   = gnt_q;
   assign owner = owner_q;
   assign busy  = (state_q == BUSY);
   assign q     = q_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter (NREQ=4, W=8, MAX_HOLD=4).
// Directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a behavioural model. Honours ARB_TIMEOUT_EN.
module tb_reg_bank_arbiter;

   localparam int NREQ     = 4;
   localparam int W        = 8;
   localparam int MAX_HOLD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  we;
   logic [31:0] wdata;
   logic [3:0]  gnt;
   logic [1:0]  owner;
   logic        busy;
   logic [7:0]  q;
   logic        timeout_evt;

   int checks = 0;
   int errors = 0;

   reg_bank_arbiter #(
      .NREQ     (NREQ),
      .W        (W),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .we          (we),
      .wdata       (wdata),
      .gnt         (gnt),
      .owner       (owner),
      .busy        (busy),
      .q           (q),
      .timeout_evt (timeout_evt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %h want %h", name, $time, got, exp);
      end
   endtask

   // Behavioural model: who holds the grant, for how many cycles, what is stored.
   bit       m_started = 1'b0;
   bit       m_busy;
   int       m_owner;
   int       m_ptr;
   int       m_hold;     // granted cycles used so far, including the current one
   bit [7:0] m_q;
   bit       m_tevt;

   always @(posedge clk) begin
      bit [7:0] nq;
      bit       frc;
      bit       others;
      int       win;
      int       c;
      m_started = 1'b1;
      if (rst) begin
         m_busy  = 1'b0;
         m_owner = 0;
         m_ptr   = 0;
         m_hold  = 0;
         m_q     = 8'h00;
         m_tevt  = 1'b0;
      end else begin
         nq = m_q;
         if (m_busy && we[m_owner]) nq = wdata[m_owner*W +: W];
         others = 1'b0;
         for (int i = 0; i < NREQ; i++) if (i != m_owner && req[i]) others = 1'b1;
         frc = 1'b0;
`ifdef ARB_TIMEOUT_EN
         frc = m_busy && req[m_owner] && (m_hold >= MAX_HOLD) && others;
`endif
         m_tevt = frc;
         if (!m_busy || !req[m_owner] || frc) begin
            win = -1;
            for (int k = 0; k < NREQ; k++) begin
               c = (m_ptr + k) % NREQ;
               if (win < 0 && req[c] && !(frc && c == m_owner)) win = c;
            end
            if (win >= 0) begin
               m_busy  = 1'b1;
               m_owner = win;
               m_ptr   = (win + 1) % NREQ;
               m_hold  = 1;
            end else begin
               m_busy = 1'b0;
            end
         end else if (m_hold < MAX_HOLD) begin
            m_hold++;
         end
         m_q = nq;
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (m_started) begin
         check("model_gnt", 32'(gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
         check("model_busy", 32'(busy), 32'(m_busy));
         check("model_q", 32'(q), 32'(m_q));
         check("model_timeout_evt", 32'(timeout_evt), 32'(m_tevt));
         if (m_busy) check("model_owner", 32'(owner), 32'(m_owner));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      int order [5];
      order = '{0, 1, 2, 3, 0};

      // Reset held two cycles with all requests up.
      rst   = 1'b1;
      req   = 4'b1111;
      we    = 4'b1111;
      wdata = 32'hDEAD_BEEF;
      repeat (2) begin
         tick();
         check("rst_gnt", 32'(gnt), 32'h0);
         check("rst_q", 32'(q), 32'h00);
         check("rst_busy", 32'(busy), 32'h0);
      end

      // Single requester write.
      rst   = 1'b0;
      req   = 4'b0100;
      we    = 4'b0100;
      wdata = 32'h00A5_0000;
      tick();
      check("single_gnt", 32'(gnt), 32'b0100);
      check("single_q_before", 32'(q), 32'h00);
      tick();
      check("single_q", 32'(q), 32'hA5);
      req = 4'b0000;
      we  = 4'b0000;
      tick();

      // Round-robin hand-off, two granted cycles each, no idle gaps.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         tick();
         check("rr_gnt_first", 32'(gnt), 32'd1 << order[n]);
         req = 4'b1111;
         tick();
         check("rr_gnt_second", 32'(gnt), 32'd1 << order[n]);
         req[order[n]] = 1'b0;
      end
      req = 4'b0000;
      tick();

      // Non-granted writer isolation.
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      req   = 4'b0010;
      we    = 4'b0010;
      wdata = 32'h0000_3C00;
      tick();
      check("iso_gnt", 32'(gnt), 32'b0010);
      tick();
      check("iso_q_own", 32'(q), 32'h3C);
      we    = 4'b1000;
      wdata = 32'hFF00_7700;
      repeat (3) begin
         tick();
         check("iso_q_hold", 32'(q), 32'h3C);
         check("iso_gnt_hold", 32'(gnt), 32'b0010);
      end
      req = 4'b0000;
      we  = 4'b0000;
      tick();

      // Hold limit.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b0001;
      tick();
      check("to_gnt_c1", 32'(gnt), 32'b0001);
      check("to_evt_c1", 32'(timeout_evt), 32'h0);
      req = 4'b0101;
`ifdef ARB_TIMEOUT_EN
      repeat (3) begin
         tick();
         check("to_gnt_hold", 32'(gnt), 32'b0001);
         check("to_evt_hold", 32'(timeout_evt), 32'h0);
      end
      tick();
      check("to_gnt_moved", 32'(gnt), 32'b0100);
      check("to_evt_pulse", 32'(timeout_evt), 32'h1);
      tick();
      check("to_gnt_after", 32'(gnt), 32'b0100);
      check("to_evt_after", 32'(timeout_evt), 32'h0);
`else
      repeat (20) begin
         tick();
         check("nto_gnt_hold", 32'(gnt), 32'b0001);
         check("nto_evt", 32'(timeout_evt), 32'h0);
      end
`endif
      req = 4'b0000;
      tick();

      // Mid-grant reset drops the grant and rewinds the pointer.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b0010;
      tick();
      check("mid_gnt", 32'(gnt), 32'b0010);
      rst = 1'b1;
      tick();
      check("mid_rst_gnt", 32'(gnt), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      req = 4'b0011;
      tick();
      check("mid_regrant", 32'(gnt), 32'b0001);
      // Pointer sits at 1 after granting 0; reset must bring it back to 0.
      req = 4'b0011;
      rst = 1'b1;
      tick();
      check("ptr_rst_gnt", 32'(gnt), 32'h0);
      rst = 1'b0;
      tick();
      check("ptr_rst_regrant", 32'(gnt), 32'b0001);
      req = 4'b0000;
      tick();

      // Randomized traffic, checked by the model every cycle.
      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 3) == 0) req = 4'($urandom());
         we    = 4'($urandom());
         wdata = $urandom();
         tick();
      end

      rst = 1'b0;
      req = 4'b0000;
      we  = 4'b0000;
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
